// File: rtl/gpio_input_filter_if.sv
// Signal bundle between the pad input conditioner and the GPIO peripheral.
// The master drives pads/config/clears; the slave (filter) returns filtered levels and interrupts.
interface gpio_input_filter_if #(
  parameter int PERIPH_GPIO_NUM = 16,
  parameter int DEBOUNCE_W      = 8
);
  localparam int NP = PERIPH_GPIO_NUM - 1;

  logic [NP:0]           pad_in;
  logic [NP:0]           pad_dir;
  logic [DEBOUNCE_W-1:0] cfg_debounce;
  logic [NP:0]           cfg_rise_en;
  logic [NP:0]           cfg_fall_en;
  logic [NP:0]           irq_clr;
  logic [NP:0]           gpio_in;
  logic [NP:0]           irq_pending;
  logic                  irq;

  modport master (
    output pad_in, pad_dir, cfg_debounce, cfg_rise_en, cfg_fall_en, irq_clr,
    input  gpio_in, irq_pending, irq
  );

  modport slave (
    input  pad_in, pad_dir, cfg_debounce, cfg_rise_en, cfg_fall_en, irq_clr,
    output gpio_in, irq_pending, irq
  );
endinterface

// File: rtl/gpio_input_filter.sv
// Per-pin 2-flop synchroniser and debounce filter feeding gpio_in, with sticky
// edge-qualified interrupt-pending bits ORed into a single irq.
module gpio_input_filter #(
  parameter int PERIPH_GPIO_NUM = 16,
  parameter int DEBOUNCE_W      = 8,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input logic                g_clk,
  input logic                g_resetn,
  gpio_input_filter_if.slave bus
);
  localparam int NP = PERIPH_GPIO_NUM - 1;

  logic [NP:0]           sync1_q;
  logic [NP:0]           sync2_q;
  logic [NP:0]           filt_q;
  logic [NP:0]           filt_d;
  logic [NP:0]           pend_q;
  logic [NP:0]           pend_d;
  logic [NP:0]           upd;
  logic [NP:0]           pend_set;
  logic [DEBOUNCE_W-1:0] cnt_q [PERIPH_GPIO_NUM];
  logic [DEBOUNCE_W-1:0] cnt_d [PERIPH_GPIO_NUM];

  // cnt only advances while below cfg_debounce, so it is bounded and never wraps.
  for (genvar gi = 0; gi <= NP; gi++) begin : g_pin
    logic differs;
    assign differs     = sync2_q[gi] ^ filt_q[gi];
    assign upd[gi]     = differs & (cnt_q[gi] >= bus.cfg_debounce);
    assign cnt_d[gi]   = (differs & ~upd[gi]) ? cnt_q[gi] + DEBOUNCE_W'(1) : '0;
  end

  assign filt_d   = filt_q ^ upd;
  assign pend_set = upd & bus.pad_dir &
                    ((sync2_q & bus.cfg_rise_en) | (~sync2_q & bus.cfg_fall_en));
  assign pend_d   = (pend_q & ~bus.irq_clr) | pend_set;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      sync1_q <= {PERIPH_GPIO_NUM{RESET_LEVEL}};
      sync2_q <= {PERIPH_GPIO_NUM{RESET_LEVEL}};
      filt_q  <= {PERIPH_GPIO_NUM{RESET_LEVEL}};
      pend_q  <= '0;
      for (int i = 0; i <= NP; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.pad_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      pend_q  <= pend_d;
      for (int i = 0; i <= NP; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gpio_in     = filt_q;
  assign bus.irq_pending = pend_q;
  assign bus.irq         = |pend_q;
endmodule

// File: tb/tb_gpio_input_filter.sv
// Bench for gpio_input_filter: directed vector table, a hand-written sequence,
// then random stimulus checked every cycle against a window-based reference model.
module tb_gpio_input_filter;
  logic        g_clk;
  logic        g_resetn;
  logic [15:0] pad, dir, rise, fall, clr;
  logic [7:0]  deb;

  int checks = 0;
  int errors = 0;

  gpio_input_filter_if #(.PERIPH_GPIO_NUM(16), .DEBOUNCE_W(8)) bus ();

  assign bus.pad_in       = pad;
  assign bus.pad_dir      = dir;
  assign bus.cfg_debounce = deb;
  assign bus.cfg_rise_en  = rise;
  assign bus.cfg_fall_en  = fall;
  assign bus.irq_clr      = clr;

  gpio_input_filter #(.PERIPH_GPIO_NUM(16), .DEBOUNCE_W(8), .RESET_LEVEL(1'b0)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with the filtered level for cfg_debounce+1 consecutive cycles.
  logic [15:0] m_d1, m_d2, m_filt, m_pend;
  logic [15:0] hist[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [15:0] p, dr, input logic [7:0] db,
                            input logic [15:0] re, fe, cl, input logic rn);
    logic [15:0] s2;
    logic [15:0] upd;
    if (!rn) begin
      m_d1   = '0;
      m_d2   = '0;
      m_filt = '0;
      m_pend = '0;
      hist.delete();
    end else begin
      s2   = m_d2;
      m_d2 = m_d1;
      m_d1 = p;
      hist.push_back(s2);
      if (hist.size() > 300) void'(hist.pop_front());
      upd = '0;
      for (int i = 0; i < 16; i++) begin
        if (hist.size() >= int'(db) + 1) begin
          upd[i] = 1'b1;
          for (int k = 0; k <= int'(db); k++)
            if (hist[hist.size() - 1 - k][i] == m_filt[i]) upd[i] = 1'b0;
        end
      end
      m_filt = m_filt ^ upd;
      m_pend = (m_pend & ~cl) | (upd & dr & ((s2 & re) | (~s2 & fe)));
    end
  endtask

  task automatic step();
    logic [15:0] p, dr, re, fe, cl;
    logic [7:0]  db;
    logic        rn;
    p = pad; dr = dir; db = deb; re = rise; fe = fall; cl = clr; rn = g_resetn;
    @(posedge g_clk);
    #1;
    model_edge(p, dr, db, re, fe, cl, rn);
    chk("model gpio_in", bus.gpio_in, m_filt);
    chk("model irq_pending", bus.irq_pending, m_pend);
    chk("model irq", 16'(bus.irq), 16'(|m_pend));
  endtask

  typedef struct {
    logic [15:0] pad, dir;
    logic [7:0]  deb;
    logic [15:0] rise, fall, clr;
    logic        rstn;
    int          cyc;
    logic [15:0] egin, epend;
    logic        eirq;
  } vec_t;

  vec_t vecs[26];

  initial begin
    //            pad       dir       deb    rise      fall      clr       rstn  cyc  gpio_in   pending  irq
    vecs[0]  = '{16'hFFFF, 16'h0000, 8'd0,  16'h0000, 16'h0000, 16'h0000, 1'b0, 3,  16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0000, 8'd0,  16'h0000, 16'h0000, 16'h0000, 1'b1, 2,  16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 8'd0,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1,  16'hFFFF, 16'h0000, 1'b0};
    vecs[3]  = '{16'hFFF7, 16'h0000, 8'd0,  16'h0000, 16'h0000, 16'h0000, 1'b1, 3,  16'hFFF7, 16'h0000, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0000, 1'b1, 6,  16'hFFF7, 16'h0000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0000, 1'b1, 1,  16'hFFFF, 16'h0008, 1'b1};
    vecs[6]  = '{16'hFFFF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0008, 1'b1, 1,  16'hFFFF, 16'h0000, 1'b0};
    vecs[7]  = '{16'hFFDF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0000, 1'b1, 7,  16'hFFDF, 16'h0000, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0000, 1'b1, 4,  16'hFFDF, 16'h0000, 1'b0};
    vecs[9]  = '{16'hFFDF, 16'h0008, 8'd4,  16'h0008, 16'h0000, 16'h0000, 1'b1, 8,  16'hFFDF, 16'h0000, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0028, 8'd4,  16'h0028, 16'h0000, 16'h0000, 1'b1, 5,  16'hFFDF, 16'h0000, 1'b0};
    vecs[11] = '{16'hFFDF, 16'h0028, 8'd4,  16'h0028, 16'h0000, 16'h0000, 1'b1, 2,  16'hFFFF, 16'h0020, 1'b1};
    vecs[12] = '{16'hFFDF, 16'h0028, 8'd4,  16'h0028, 16'h0000, 16'h0000, 1'b1, 5,  16'hFFDF, 16'h0020, 1'b1};
    vecs[13] = '{16'hFFDF, 16'h0028, 8'd4,  16'h0028, 16'h0000, 16'hFFFF, 1'b1, 1,  16'hFFDF, 16'h0000, 1'b0};
    vecs[14] = '{16'hFFDE, 16'h0000, 8'd0,  16'h0000, 16'h0001, 16'h0000, 1'b1, 3,  16'hFFDE, 16'h0000, 1'b0};
    vecs[15] = '{16'hFFDA, 16'h0004, 8'd0,  16'h0004, 16'h0004, 16'h0000, 1'b1, 3,  16'hFFDA, 16'h0004, 1'b1};
    vecs[16] = '{16'hFFDE, 16'h0004, 8'd0,  16'h0004, 16'h0004, 16'h0000, 1'b1, 2,  16'hFFDA, 16'h0004, 1'b1};
    vecs[17] = '{16'hFFDE, 16'h0004, 8'd0,  16'h0004, 16'h0004, 16'h0004, 1'b1, 1,  16'hFFDE, 16'h0004, 1'b1};
    vecs[18] = '{16'hFFDE, 16'h0004, 8'd0,  16'h0004, 16'h0004, 16'h0004, 1'b1, 1,  16'hFFDE, 16'h0000, 1'b0};
    vecs[19] = '{16'hFFDE, 16'h0004, 8'd0,  16'h0004, 16'h0004, 16'h0000, 1'b1, 1,  16'hFFDE, 16'h0000, 1'b0};
    vecs[20] = '{16'hFF5E, 16'h0000, 8'd20, 16'h0000, 16'h0000, 16'h0000, 1'b1, 12, 16'hFFDE, 16'h0000, 1'b0};
    vecs[21] = '{16'hFF5E, 16'h0000, 8'd3,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1,  16'hFF5E, 16'h0000, 1'b0};
    vecs[22] = '{16'hFE5E, 16'h0100, 8'd20, 16'h0000, 16'h0100, 16'h0000, 1'b1, 8,  16'hFF5E, 16'h0000, 1'b0};
    vecs[23] = '{16'hFE5E, 16'h0100, 8'd20, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1,  16'h0000, 16'h0000, 1'b0};
    vecs[24] = '{16'hFFFF, 16'h0100, 8'd20, 16'h0000, 16'h0100, 16'h0000, 1'b1, 22, 16'h0000, 16'h0000, 1'b0};
    vecs[25] = '{16'hFFFF, 16'h0100, 8'd20, 16'h0000, 16'h0100, 16'h0000, 1'b1, 1,  16'hFFFF, 16'h0000, 1'b0};

    pad = '0; dir = '0; deb = '0; rise = '0; fall = '0; clr = '0; g_resetn = 1'b0;
    m_d1 = '0; m_d2 = '0; m_filt = '0; m_pend = '0;

    for (int v = 0; v < 26; v++) begin
      pad = vecs[v].pad; dir = vecs[v].dir; deb = vecs[v].deb;
      rise = vecs[v].rise; fall = vecs[v].fall; clr = vecs[v].clr;
      g_resetn = vecs[v].rstn;
      repeat (vecs[v].cyc) step();
      chk($sformatf("vec%0d gpio_in", v), bus.gpio_in, vecs[v].egin);
      chk($sformatf("vec%0d irq_pending", v), bus.irq_pending, vecs[v].epend);
      chk($sformatf("vec%0d irq", v), 16'(bus.irq), 16'(vecs[v].eirq));
      $display("vec %0d: pad=%h dir=%h deb=%0d clr=%h rstn=%0b -> gpio_in=%h pending=%h irq=%0b",
               v, pad, dir, deb, clr, g_resetn, bus.gpio_in, bus.irq_pending, bus.irq);
    end

    // Changing direction/enables must not drop an existing pending bit.
    deb = 8'd0; dir = 16'h0001; fall = 16'h0001; rise = '0; clr = '0; pad = 16'hFFFE;
    repeat (3) step();
    chk("seq fall pend", bus.irq_pending, 16'h0001);
    dir = '0; fall = '0;
    repeat (2) step();
    chk("seq keep pend", bus.irq_pending, 16'h0001);
    clr = 16'h0001;
    step();
    clr = '0;
    chk("seq clr pend", bus.irq_pending, 16'h0000);
    chk("seq clr irq", 16'(bus.irq), 16'h0000);
    $display("seq: pending held across dir/enable change, cleared by irq_clr");

    for (int blk = 0; blk < 8; blk++) begin
      deb  = 8'($urandom_range(0, 6));
      dir  = 16'($urandom);
      rise = 16'($urandom);
      fall = 16'($urandom);
      for (int c = 0; c < 300; c++) begin
        pad      = pad ^ 16'($urandom & $urandom & $urandom);
        clr      = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0000;
        g_resetn = ($urandom_range(0, 249) != 0);
        if ($urandom_range(0, 99) == 0) deb = 8'($urandom_range(0, 6));
        step();
      end
      $display("random block %0d: deb=%0d gpio_in=%h pending=%h checks=%0d",
               blk, deb, bus.gpio_in, bus.irq_pending, checks);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
